// File: rtl/grid_encoder.sv
// Transmit side of the grid/move byte protocol: streams GRID_HEADER, the latched 8x8 board,
// MOVE_HEADER and the preloaded move list over a valid/ready byte link.
module grid_encoder #(
  parameter int WIDTH       = 8,
  parameter int HEIGHT      = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MOVE_WIDTH  = 16,
  parameter int MAX_MOVES   = 220,
  parameter logic [DATA_WIDTH-1:0] GRID_HEADER = 8'b11010101,
  parameter logic [DATA_WIDTH-1:0] MOVE_HEADER = 8'b11101010
) (
  input  logic                                 clk,
  input  logic                                 nrst,
  input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0]   grid_id,
  input  logic                                 mv_we,
  input  logic [7:0]                           mv_waddr,
  input  logic [MOVE_WIDTH-1:0]                mv_wdata,
  input  logic [7:0]                           n_moves,
  input  logic                                 start,
  input  logic                                 tx_ready,
  output logic                                 tx_v,
  output logic [DATA_WIDTH-1:0]                tx_d,
  output logic                                 busy,
  output logic                                 done
);

  localparam int CELLS = HEIGHT * WIDTH;
  localparam int CW    = $clog2(CELLS);

  typedef enum logic [2:0] {IDLE, GHDR, GRID, MHDR, MOVES, FIN} state_t;

  state_t                              state_q, state_d;
  logic [CELLS-1:0][DATA_WIDTH-1:0]    grid_q, grid_d;
  logic [7:0]                          nmv_q, nmv_d;
  logic [6:0]                          cnt_q, cnt_d;
  logic [7:0]                          idx_q, idx_d;
  logic                                half_q, half_d;
  logic                                tx_v_q, tx_v_d;
  logic [DATA_WIDTH-1:0]               tx_d_q, tx_d_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;

  // Move buffer is deliberately not reset; host preloads it between frames.
  logic [MOVE_WIDTH-1:0] mv_mem [MAX_MOVES];

  logic       xfer;
  logic [6:0] cnt_inc;
  logic [7:0] idx_inc;
  logic [7:0] nmv_clamp;

  assign xfer      = tx_v_q && tx_ready;
  assign cnt_inc   = cnt_q + 7'd1;
  assign idx_inc   = idx_q + 8'd1;
  assign nmv_clamp = (n_moves > 8'(MAX_MOVES)) ? 8'(MAX_MOVES) : n_moves;

  always_ff @(posedge clk) begin
    if (mv_we && !busy_q && (mv_waddr < 8'(MAX_MOVES)))
      mv_mem[mv_waddr] <= mv_wdata;
  end

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    nmv_d   = nmv_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    half_d  = half_q;
    tx_v_d  = tx_v_q;
    tx_d_d  = tx_d_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        grid_d  = grid_id;
        nmv_d   = nmv_clamp;
        cnt_d   = '0;
        idx_d   = '0;
        half_d  = 1'b0;
        state_d = GHDR;
        tx_v_d  = 1'b1;
        tx_d_d  = GRID_HEADER;
        busy_d  = 1'b1;
      end
      GHDR: if (xfer) begin
        state_d = GRID;
        cnt_d   = '0;
        tx_d_d  = grid_q[0];
      end
      GRID: if (xfer) begin
        if (cnt_q == 7'(CELLS-1)) begin
          state_d = MHDR;
          tx_d_d  = MOVE_HEADER;
        end else begin
          cnt_d   = cnt_inc;
          tx_d_d  = grid_q[cnt_inc[CW-1:0]];
        end
      end
      MHDR: if (xfer) begin
        idx_d  = '0;
        half_d = 1'b0;
        if (nmv_q == 8'd0) begin
          state_d = FIN;
          tx_v_d  = 1'b0;
          tx_d_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = MOVES;
          tx_d_d  = mv_mem[0][MOVE_WIDTH-1 -: DATA_WIDTH];
        end
      end
      MOVES: if (xfer) begin
        if (!half_q) begin
          half_d = 1'b1;
          tx_d_d = mv_mem[idx_q][DATA_WIDTH-1:0];
        end else if (idx_q == nmv_q - 8'd1) begin
          state_d = FIN;
          tx_v_d  = 1'b0;
          tx_d_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d  = idx_inc;
          half_d = 1'b0;
          tx_d_d = mv_mem[idx_inc][MOVE_WIDTH-1 -: DATA_WIDTH];
        end
      end
      FIN: begin
        // start here is intentionally dropped; frames restart only from IDLE
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        half_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      grid_q  <= '0;
      nmv_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      half_q  <= 1'b0;
      tx_v_q  <= 1'b0;
      tx_d_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      nmv_q   <= nmv_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      half_q  <= half_d;
      tx_v_q  <= tx_v_d;
      tx_d_q  <= tx_d_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_v = tx_v_q;
  assign tx_d = tx_d_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_grid_encoder.sv
// Scoreboard bench for grid_encoder: drivers push expected bytes, a negedge monitor
// pops and compares every accepted byte.
module tb_grid_encoder;
  logic         clk = 1'b0;
  logic         nrst;
  logic [511:0] grid_id;
  logic         mv_we;
  logic [7:0]   mv_waddr;
  logic [15:0]  mv_wdata;
  logic [7:0]   n_moves;
  logic         start;
  logic         tx_ready;
  logic         tx_v;
  logic [7:0]   tx_d;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  grid_encoder dut (
    .clk(clk), .nrst(nrst), .grid_id(grid_id), .mv_we(mv_we), .mv_waddr(mv_waddr),
    .mv_wdata(mv_wdata), .n_moves(n_moves), .start(start), .tx_ready(tx_ready),
    .tx_v(tx_v), .tx_d(tx_d), .busy(busy), .done(done)
  );

  int         checks = 0;
  int         errors = 0;
  int         popped = 0;
  int         frame_base = 0;
  int         exp_len = 0;
  logic [7:0] sb[$];
  logic [7:0] mon_exp;
  logic [15:0] mv_model [220];

  // Monitor: every accepted byte must match the head of the scoreboard.
  always @(negedge clk) begin
    if (nrst) begin
      if (busy) begin
        checks++;
        if (!tx_v) begin
          errors++;
          $display("FAIL gap: tx_v=%0b while busy, required 1", tx_v);
        end
      end
      if (tx_v && tx_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %h, required no byte", tx_d);
        end else begin
          mon_exp = sb.pop_front();
          if (tx_d !== mon_exp) begin
            errors++;
            $display("FAIL stream_byte[%0d]: got %h, required %h", popped - frame_base, tx_d, mon_exp);
          end
        end
        popped++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic write_mv(input int addr, input logic [15:0] data, input bit upd);
    mv_we    = 1'b1;
    mv_waddr = 8'(addr);
    mv_wdata = data;
    if (upd && addr < 220) mv_model[addr] = data;
    tick();
    mv_we = 1'b0;
  endtask

  task automatic start_frame(input int n);
    int nc;
    nc = (n > 220) ? 220 : n;
    sb.push_back(8'hD5);
    for (int i = 0; i < 64; i++) sb.push_back(grid_id[i*8 +: 8]);
    sb.push_back(8'hEA);
    for (int i = 0; i < nc; i++) begin
      sb.push_back(mv_model[i][15:8]);
      sb.push_back(mv_model[i][7:0]);
    end
    frame_base = popped;
    exp_len    = 66 + 2 * nc;
    n_moves    = 8'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("start_tx_v", {31'd0, tx_v}, 32'd1);
    check("start_hdr", {24'd0, tx_d}, 32'hD5);
    check("start_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_frame();
    int k;
    k = 0;
    while (!done && k < 3000) begin
      tick();
      k++;
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    check("frame_len", 32'(popped - frame_base), 32'(exp_len));
    tick();
    check("done_once", {31'd0, done}, 32'd0);
    check("idle_tx_v", {31'd0, tx_v}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_popped(input int target);
    int k;
    k = 0;
    while (popped < target && k < 3000) begin
      tick();
      k++;
    end
    check("wait_popped", 32'(popped), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0; mv_we = 1'b0; mv_waddr = '0; mv_wdata = '0;
    n_moves = '0; start = 1'b0; tx_ready = 1'b1; grid_id = '0;
    for (int i = 0; i < 220; i++) mv_model[i] = '0;
    #1;
    check("rst_tx_v", {31'd0, tx_v}, 32'd0);
    check("rst_tx_d", {24'd0, tx_d}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    tick(); tick();
    nrst = 1'b1;
    tick();

    // empty board, no moves
    for (int i = 0; i < 64; i++) grid_id[i*8 +: 8] = 8'h7F;
    start_frame(0);
    finish_frame();

    // counting board, two moves
    for (int i = 0; i < 64; i++) grid_id[i*8 +: 8] = 8'(i);
    write_mv(0, 16'hA1B2, 1'b1);
    write_mv(1, 16'h0C3D, 1'b1);
    start_frame(2);
    finish_frame();

    // sink stall at grid byte 10
    start_frame(2);
    wait_popped(frame_base + 11);
    tx_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("stall_tx_v", {31'd0, tx_v}, 32'd1);
      check("stall_tx_d", {24'd0, tx_d}, 32'h0A);
      tick();
    end
    tx_ready = 1'b1;
    finish_frame();

    // start and buffer write during a frame must not disturb it
    start_frame(2);
    wait_popped(frame_base + 5);
    start = 1'b1;
    write_mv(0, 16'hFFFF, 1'b0);
    start = 1'b0;
    finish_frame();

    // reset while grid byte 30 is presented
    start_frame(0);
    wait_popped(frame_base + 31);
    check("pre_rst_byte", {24'd0, tx_d}, 32'h1E);
    #2;
    nrst = 1'b0;
    #1;
    check("abort_tx_v", {31'd0, tx_v}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_tx_d", {24'd0, tx_d}, 32'd0);
    sb.delete();
    tick();
    nrst = 1'b1;
    tick();
    start_frame(0);
    finish_frame();

    // full buffer with n_moves clamped from 255 to 220
    for (int i = 0; i < 220; i++) write_mv(i, {8'(i), 8'(i * 3 + 1)}, 1'b1);
    write_mv(220, 16'hDEAD, 1'b1);
    start_frame(255);
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
